// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: opcode encodings and FSM states.
// Opcode encodings match the earlier combinational 8-bit ALU.
package alu_mc_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_ROL = 4'b1010;
   localparam logic [3:0] OP_ROR = 4'b1011;
   localparam logic [3:0] OP_MUL = 4'b1110;
   localparam logic [3:0] OP_DIV = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc iterative datapath: shift-add multiply and restoring divide.
// One step per cycle; lo/hi hold product or quotient/remainder.
module alu_mc_iter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             done
);

   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   trial;

   // one multiply or divide iteration, or operand load on start
   always_comb begin
      lo_d   = lo_q;
      hi_d   = hi_q;
      b_d    = b_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      sum    = {1'b0, hi_q} + {1'b0, b_q};
      shl    = {hi_q, lo_q[WIDTH-1]};
      trial  = shl - {1'b0, b_q};
      if (start) begin
         lo_d   = a;
         hi_d   = '0;
         b_d    = b;
         mode_d = mode;
         cnt_d  = CNT_W'(WIDTH);
      end else if (step) begin
         cnt_d = cnt_q - 1'b1;
         if (!mode_q) begin
            if (lo_q[0]) begin
               {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end else begin
               {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
         end else if (!trial[WIDTH]) begin
            hi_d = trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = shl[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // iteration state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q   <= '0;
         hi_q   <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         lo_q   <= lo_d;
         hi_q   <= hi_d;
         b_q    <= b_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
      end
   end

   assign lo   = lo_q;
   assign hi   = hi_q;
   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_mc.sv
// alu_mc top: handshake FSM, single-cycle ops, result registers.
// MUL/DIV results are read straight from the iterative datapath.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry_out,
   output logic             zero,
   output logic             div_by_zero,
   output logic             illegal_op
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
   logic             cy_q, cy_d, z_q, z_d;
   logic             dbz_q, dbz_d, ill_q, ill_d;
   logic             iter_q, iter_d, mul_q, mul_d;
   logic [WIDTH-1:0] s_res, s_hi;
   logic             s_cy, s_dbz, s_ill, go_iter;
   logic             start;
   logic [WIDTH-1:0] it_lo, it_hi;
   logic             it_done;

   // decode and evaluate the single-cycle ops from the live inputs
   always_comb begin
      s_res   = '0;
      s_hi    = '0;
      s_cy    = 1'b0;
      s_dbz   = 1'b0;
      s_ill   = 1'b0;
      go_iter = 1'b0;
      case (opcode)
         OP_ADD: {s_cy, s_res} = {1'b0, A} + {1'b0, B};
         OP_SUB: begin
            s_res = A - B;
            s_cy  = (A < B);
         end
         OP_AND: s_res = A & B;
         OP_OR:  s_res = A | B;
         OP_XOR: s_res = A ^ B;
         OP_SHL: begin
            s_res = {A[WIDTH-2:0], 1'b0};
            s_cy  = A[WIDTH-1];
         end
         OP_SHR: begin
            s_res = {1'b0, A[WIDTH-1:1]};
            s_cy  = A[0];
         end
         OP_ROL: begin
            s_res = {A[WIDTH-2:0], A[WIDTH-1]};
            s_cy  = A[WIDTH-1];
         end
         OP_ROR: begin
            s_res = {A[0], A[WIDTH-1:1]};
            s_cy  = A[0];
         end
         OP_MUL: go_iter = 1'b1;
         OP_DIV: begin
            if (B == '0) begin
               s_res = '1;
               s_hi  = A;
               s_dbz = 1'b1;
            end else begin
               go_iter = 1'b1;
            end
         end
         default: s_ill = 1'b1;
      endcase
   end

   // handshake FSM; result registers load on acceptance
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      hi_d    = hi_q;
      cy_d    = cy_q;
      z_d     = z_q;
      dbz_d   = dbz_q;
      ill_d   = ill_q;
      iter_d  = iter_q;
      mul_d   = mul_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               res_d  = s_res;
               hi_d   = s_hi;
               cy_d   = s_cy;
               z_d    = (s_res == '0);
               dbz_d  = s_dbz;
               ill_d  = s_ill;
               iter_d = go_iter;
               mul_d  = (opcode == OP_MUL);
               start  = go_iter;
               if (!go_iter) begin
                  state_d = DONE;
               end else if (opcode == OP_MUL) begin
                  state_d = MUL;
               end else begin
                  state_d = DIV;
               end
            end
         end
         MUL, DIV: begin
            if (it_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         res_q   <= '0;
         hi_q    <= '0;
         cy_q    <= 1'b0;
         z_q     <= 1'b0;
         dbz_q   <= 1'b0;
         ill_q   <= 1'b0;
         iter_q  <= 1'b0;
         mul_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         cy_q    <= cy_d;
         z_q     <= z_d;
         dbz_q   <= dbz_d;
         ill_q   <= ill_d;
         iter_q  <= iter_d;
         mul_q   <= mul_d;
      end
   end

   alu_mc_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (opcode == OP_DIV),
      .step  ((state_q == MUL) || (state_q == DIV)),
      .a     (A),
      .b     (B),
      .lo    (it_lo),
      .hi    (it_hi),
      .done  (it_done)
   );

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign result      = iter_q ? it_lo : res_q;
   assign result_hi   = iter_q ? it_hi : hi_q;
   assign carry_out   = iter_q ? (mul_q & (|it_hi)) : cy_q;
   assign zero        = iter_q ? (mul_q ? ~|{it_hi, it_lo} : ~|it_lo) : z_q;
   assign div_by_zero = dbz_q;
   assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// alu_mc directed testbench.
// Hand-computed vectors for WIDTH=8.
module tb_alu_mc;
   import alu_mc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic [3:0] opcode = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic [7:0] result_hi;
   logic       carry_out;
   logic       zero;
   logic       div_by_zero;
   logic       illegal_op;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (A),
      .B           (B),
      .opcode      (opcode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .result_hi   (result_hi),
      .carry_out   (carry_out),
      .zero        (zero),
      .div_by_zero (div_by_zero),
      .illegal_op  (illegal_op)
   );

   // present one request, return edges from acceptance to out_valid
   task automatic issue(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, output int cyc);
      @(negedge clk);
      opcode = op;
      A = a;
      B = b;
      out_ready = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         #1 cyc++;
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
      end
      total++;
      if ({result, result_hi, carry_out, zero, div_by_zero, illegal_op} !== 20'h0) begin
         bad++;
         $display("FAIL reset_out got res=%h hi=%h c=%b z=%b dz=%b il=%b exp all 0",
                  result, result_hi, carry_out, zero, div_by_zero, illegal_op);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [3:0] ops [13] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_XOR,
                               OP_SHR, OP_ROL, OP_ROR, OP_SHL, OP_SHL, OP_SUB};
      logic [7:0] av [13] = '{8'h0F, 8'hFF, 8'h0F, 8'h01, 8'hF0, 8'hF0, 8'hF0,
                              8'h8F, 8'h8F, 8'h8F, 8'h0F, 8'h80, 8'h55};
      logic [7:0] bv [13] = '{8'h01, 8'h01, 8'h01, 8'h0F, 8'h3C, 8'h3C, 8'h3C,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
      logic [7:0] er [13] = '{8'h10, 8'h00, 8'h0E, 8'hF2, 8'h30, 8'hFC, 8'hCC,
                              8'h47, 8'h1F, 8'hC7, 8'h1E, 8'h00, 8'h00};
      logic       ec [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      int cyc;
      for (int i = 0; i < 13; i++) begin
         issue(ops[i], av[i], bv[i], cyc);
         total++;
         if (cyc !== 1) begin
            bad++;
            $display("FAIL single%0d_lat got=%0d exp=1", i, cyc);
         end
         total++;
         if (result !== er[i] || carry_out !== ec[i]) begin
            bad++;
            $display("FAIL single%0d_res got=%h/c%b exp=%h/c%b", i, result, carry_out, er[i], ec[i]);
         end
         total++;
         if (zero !== (er[i] == 8'h00) || result_hi !== 8'h00) begin
            bad++;
            $display("FAIL single%0d_zhi got z=%b hi=%h exp z=%b hi=00", i, zero, result_hi, er[i] == 8'h00);
         end
         total++;
         if (div_by_zero !== 1'b0 || illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL single%0d_flags got dz=%b il=%b exp 0 0", i, div_by_zero, illegal_op);
         end
         release_out();
      end
   endtask

   task automatic test_mul();
      int cyc;
      issue(OP_MUL, 8'h03, 8'h02, cyc);
      total++;
      if (cyc !== 9) begin
         bad++;
         $display("FAIL mul_lat got=%0d exp=9", cyc);
      end
      total++;
      if (result !== 8'h06 || result_hi !== 8'h00 || carry_out !== 1'b0 || zero !== 1'b0) begin
         bad++;
         $display("FAIL mul_small got=%h:%h c%b z%b exp=00:06 c0 z0", result_hi, result, carry_out, zero);
      end
      release_out();
      issue(OP_MUL, 8'hFF, 8'hFF, cyc);
      total++;
      if (result !== 8'h01 || result_hi !== 8'hFE || carry_out !== 1'b1 || zero !== 1'b0) begin
         bad++;
         $display("FAIL mul_max got=%h:%h c%b z%b exp=FE:01 c1 z0", result_hi, result, carry_out, zero);
      end
      release_out();
      issue(OP_MUL, 8'h00, 8'h5A, cyc);
      total++;
      if (result !== 8'h00 || result_hi !== 8'h00 || zero !== 1'b1 || carry_out !== 1'b0) begin
         bad++;
         $display("FAIL mul_zero got=%h:%h c%b z%b exp=00:00 c0 z1", result_hi, result, carry_out, zero);
      end
      release_out();
   endtask

   task automatic test_div();
      int cyc;
      issue(OP_DIV, 8'h08, 8'h02, cyc);
      total++;
      if (cyc !== 9) begin
         bad++;
         $display("FAIL div_lat got=%0d exp=9", cyc);
      end
      total++;
      if (result !== 8'h04 || result_hi !== 8'h00 || carry_out !== 1'b0 || zero !== 1'b0) begin
         bad++;
         $display("FAIL div_8_2 got q=%h r=%h c%b z%b exp q=04 r=00 c0 z0", result, result_hi, carry_out, zero);
      end
      release_out();
      issue(OP_DIV, 8'h64, 8'h07, cyc);
      total++;
      if (result !== 8'h0E || result_hi !== 8'h02) begin
         bad++;
         $display("FAIL div_100_7 got q=%h r=%h exp q=0E r=02", result, result_hi);
      end
      release_out();
      issue(OP_DIV, 8'h07, 8'h00, cyc);
      total++;
      if (cyc !== 1) begin
         bad++;
         $display("FAIL div0_lat got=%0d exp=1", cyc);
      end
      total++;
      if (result !== 8'hFF || result_hi !== 8'h07 || div_by_zero !== 1'b1 || zero !== 1'b0) begin
         bad++;
         $display("FAIL div0 got q=%h r=%h dz=%b z=%b exp q=FF r=07 dz=1 z=0",
                  result, result_hi, div_by_zero, zero);
      end
      release_out();
      issue(4'b0101, 8'h12, 8'h34, cyc);
      total++;
      if (cyc !== 1 || illegal_op !== 1'b1 || zero !== 1'b1 || div_by_zero !== 1'b0) begin
         bad++;
         $display("FAIL illegal got lat=%0d il=%b z=%b dz=%b exp lat=1 il=1 z=1 dz=0",
                  cyc, illegal_op, zero, div_by_zero);
      end
      total++;
      if (result !== 8'h00 || result_hi !== 8'h00) begin
         bad++;
         $display("FAIL illegal_res got=%h:%h exp=00:00", result_hi, result);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      int cyc;
      issue(OP_ADD, 8'h12, 8'h34, cyc);
      @(negedge clk);
      opcode = OP_SUB;
      A = 8'h01;
      B = 8'h02;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h46 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL hold%0d got vld=%b rdy=%b res=%h c=%b exp vld=1 rdy=0 res=46 c=0",
                     i, out_valid, in_ready, result, carry_out);
         end
      end
      in_valid = 1'b0;
      release_out();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL drop got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_mul();
      int cyc;
      @(negedge clk);
      opcode = OP_MUL;
      A = 8'h11;
      B = 8'h22;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h00) begin
         bad++;
         $display("FAIL rst_mid got vld=%b rdy=%b res=%h exp vld=0 rdy=1 res=00",
                  out_valid, in_ready, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(OP_ADD, 8'h01, 8'h02, cyc);
      total++;
      if (cyc !== 1 || result !== 8'h03 || carry_out !== 1'b0 || zero !== 1'b0) begin
         bad++;
         $display("FAIL post_rst_add got lat=%0d res=%h c=%b z=%b exp lat=1 res=03 c0 z0",
                  cyc, result, carry_out, zero);
      end
      release_out();
   endtask

   initial begin
      test_reset();
      test_single();
      test_mul();
      test_div();
      test_backpressure();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
